rf_wb_ctrl: RTL
===============

# rf_wb_ctrl

Writeback controller for the register file: it shares the register file's single write port between two writeback requesters and keeps a per-register pending-write scoreboard. The requesters are port 0, the single-cycle ALU path, and port 1, the long-latency load/multi-cycle unit. It sits between the execute/memory units and `rf` in the single-cycle/multi-cycle core (`BYPASS_EN=0`). It drives `rf`'s `i_rd_*` inputs from a registered write stage, and tells decode when a source or destination register still has a write in flight.

## Interface
- `RR_EN`, default 1: 1 selects round-robin arbitration between ports; 0 selects fixed priority, where port 0 always wins.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_issue_valid` in 1: decode issues an instruction that will write `i_issue_rd`.
- `i_issue_rd` in 5: destination register of the issuing instruction.
- `o_issue_ready` out 1: issue allowed this cycle. Deasserted on a WAW hazard.
- `i_rs1_addr`, `i_rs2_addr` in 5 each: decode source registers.
- `o_rs1_busy`, `o_rs2_busy` out 1 each: the source register has a pending write.
- `i_wb0_valid` in 1, `i_wb0_addr` in 5, `i_wb0_data` in 32: port 0 writeback request.
- `o_wb0_ready` out 1: port 0 request accepted this cycle.
- `i_wb1_valid` in 1, `i_wb1_addr` in 5, `i_wb1_data` in 32: port 1 writeback request.
- `o_wb1_ready` out 1: port 1 request accepted this cycle.
- `o_rd_wen` out 1, `o_rd_waddr` out 5, `o_rd_wdata` out 32: registered outputs to the `rf` write port.

## Operation
- Scoreboard: a 32-bit `busy` register. Bit 0 is constant 0.
- Issue handshake fires when `i_issue_valid && o_issue_ready`.
  - `o_issue_ready = (i_issue_rd==0) || !busy[i_issue_rd]`.
  - On fire with `rd!=0`, `busy[rd]` is set at the clock edge.
- `o_rsN_busy = busy[i_rsN_addr]`. It is combinational from the registered `busy`, and always 0 for x0.
- Arbitration:
  - Only one request is accepted per cycle. The output stage always drains, so ready equals grant and no request is backpressured except by losing arbitration.
  - `RR_EN=1`: a 1-bit `last` pointer records the last granted port. On a conflict, the other port wins. With a single requester, that requester wins. `last` updates only when a grant occurs.
  - `RR_EN=0`: port 0 always wins, and port 1 is granted only when port 0 is idle.
  - `o_wbN_ready` is combinational from the valids and `last`, and never asserts without the matching valid.
- Write stage: on a grant, the winner's addr and data are registered.
  - `o_rd_wen` is set to 1 if addr!=0. If addr==0, it is 0 and the write is dropped.
  - With no grant, `o_rd_wen` goes to 0. Addr and data hold their last value.
- Busy clear: on a cycle with `o_rd_wen=1`, `busy[o_rd_waddr]` is cleared at the edge that ends that cycle. This is the same edge at which `rf` commits the write.
- Writeback to a non-busy register is legal: the write proceeds and the clear has no effect.
- Set and clear of the same register in the same edge cannot occur, because issue is blocked while that register is busy.
- Set and clear of different registers in the same edge both take effect.

## Timing
- Reset values:
  - `busy` = 0 and `last` = 1, so port 0 wins the first conflict.
  - `o_rd_wen` = 0, `o_rd_waddr` = 0, `o_rd_wdata` = 0.
  - `o_issue_ready` = 1 and `o_rsN_busy` = 0 in the cycle after reset.
- Reset mid-operation: everything pending is discarded. A write held in the output stage is not performed (`o_rd_wen` = 0 after the reset edge).
- Latency: request accepted in cycle N → `o_rd_wen` high in N+1 → `rf` is updated and the busy bit is clear from N+2.
  - During N+1, the register still reads busy. This is required because `rf` has no bypass.
- Throughput: one write per cycle sustained. Under continuous contention with `RR_EN=1`, grants alternate 0,1,0,1.
- Issue and `o_rsN_busy` take effect the cycle after the issuing edge.

## Structure
- Shared package (`core_pkg`): `REG_AW=5`, `XLEN=32`, `NUM_REGS=32`.
- One sub-module is natural: `wb_rr_arb`, the 2-port arbiter with `last` pointer and `RR_EN` mode.
- The scoreboard and write stage stay in `rf_wb_ctrl`.
- The bench instantiates `rf_wb_ctrl` + `rf #(.BYPASS_EN(0))` together.

## Test plan
- **Reset and basic write:** reset; issue rd=5; wb0 addr=5 data=0xDEADBEEF. Expect:
  - `o_rs1_busy(5)`=1 from the next cycle.
  - `o_rd_wen`=1 in N+1.
  - `rf` x5=0xDEADBEEF and busy=0 in N+2.
- **Contention, round-robin:** `RR_EN=1`; both ports valid for 4 cycles with addrs 1/2. Expect:
  - Grants go 0,1,0,1.
  - x1 and x2 are each written twice, last data wins.
  - With `RR_EN=0`, port 1 is starved until port 0 drops valid.
- **WAW stall:** issue rd=7, then issue rd=7 again. Expect:
  - `o_issue_ready`=0 until the cycle after the x7 write commits.
  - Simultaneously issuing rd=8 while x3 clears sets bit 8 and clears bit 3.
- **x0 handling:** issue rd=0 → ready=1, busy stays 0. wb0 addr=0 data=0x1234 → ready=1, `o_rd_wen`=0, x0 reads 0.
- **Reset mid-operation:** grant wb1 addr=9, assert `i_rst` in N+1. Expect x9 unchanged, all busy bits 0, and `o_rd_wen`=0.
- **Back-to-back same register:** writes to x4 (0xA then 0xB) on consecutive cycles via port 0. Expect x4=0xB and busy cleared after the second commit.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared core constants and types for the register-file writeback path.
// Contents: register address/data widths, register count, write-stage record.
package rf_wb_ctrl_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    // Registered write stage feeding the rf write port.
    typedef struct packed {
        logic      wen;
        reg_addr_t waddr;
        xlen_t     wdata;
    } wb_stage_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bundle of decode, writeback-requester and rf-write signals around rf_wb_ctrl.
// master: decode + execute/memory units + rf side; slave: the writeback controller.
//   issue_valid/issue_rd/issue_ready : destination-register issue handshake
//   rs1/rs2_addr, rs1/rs2_busy       : source pending-write query
//   wbN_valid/addr/data/ready        : writeback request ports 0 (ALU) and 1 (load/mul)
//   rd_wen/rd_waddr/rd_wdata         : registered rf write port
interface rf_wb_ctrl_if;
    import rf_wb_ctrl_pkg::*;

    logic      issue_valid;
    reg_addr_t issue_rd;
    logic      issue_ready;

    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_busy;
    logic      rs2_busy;

    logic      wb0_valid;
    reg_addr_t wb0_addr;
    xlen_t     wb0_data;
    logic      wb0_ready;

    logic      wb1_valid;
    reg_addr_t wb1_addr;
    xlen_t     wb1_data;
    logic      wb1_ready;

    logic      rd_wen;
    reg_addr_t rd_waddr;
    xlen_t     rd_wdata;

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
        input  issue_ready, rs1_busy, rs2_busy, wb0_ready, wb1_ready,
        input  rd_wen, rd_waddr, rd_wdata
    );

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
        output issue_ready, rs1_busy, rs2_busy, wb0_ready, wb1_ready,
        output rd_wen, rd_waddr, rd_wdata
    );

endinterface

// File: rtl/rf.sv
// rf: 32 x XLEN register file, one write port, two combinational read ports.
// x0 reads as zero and ignores writes; writes are suppressed while i_rst is high.
// BYPASS_EN=1 forwards the write data to a read of the same register in that cycle.
// Ports: i_clk, i_rst, i_rd_wen/i_rd_waddr/i_rd_wdata, i_rsN_addr -> o_rsN_data.
module rf
    import rf_wb_ctrl_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_rd_wen,
    input  reg_addr_t i_rd_waddr,
    input  xlen_t     i_rd_wdata,
    input  reg_addr_t i_rs1_addr,
    output xlen_t     o_rs1_data,
    input  reg_addr_t i_rs2_addr,
    output xlen_t     o_rs2_data
);

    xlen_t regs [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (!i_rst && i_rd_wen && i_rd_waddr != '0) begin
            regs[i_rd_waddr] <= i_rd_wdata;
        end
    end

    logic byp1, byp2;
    assign byp1 = BYPASS_EN && i_rd_wen && (i_rd_waddr == i_rs1_addr);
    assign byp2 = BYPASS_EN && i_rd_wen && (i_rd_waddr == i_rs2_addr);

    assign o_rs1_data = (i_rs1_addr == '0) ? '0 : byp1 ? i_rd_wdata : regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 : byp2 ? i_rd_wdata : regs[i_rs2_addr];

endmodule

// File: rtl/rf_wb_ctrl_arb.sv
// wb_rr_arb: two-port writeback arbiter, one grant per cycle.
// RR_EN=1: on conflict the port not granted last wins; RR_EN=0: port 0 has priority.
// Ports: i_clk, i_rst (sync, active-high), req0/req1 in, gnt0/gnt1 out (combinational).
module wb_rr_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // Last granted port; reset to 1 so port 0 takes the first conflict.
    logic last_q, last_d;

    always_comb begin
        gnt0   = req0;
        gnt1   = req1 && !req0;
        if (RR_EN && req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: shares the rf write port between two writeback requesters and keeps a
// per-register pending-write scoreboard for decode.
// Ports: i_clk, i_rst (sync, active-high), bus (rf_wb_ctrl_if.slave) carrying the
// issue handshake, source busy query, two writeback ports and the registered rf write.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rf_wb_ctrl_if.slave  bus
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    wb_stage_t           wb_q, wb_d;
    logic                gnt0, gnt1;
    logic                issue_fire;

    // WAW guard: a register with a write in flight cannot be re-issued.
    assign bus.issue_ready = (bus.issue_rd == '0) || !busy_q[bus.issue_rd];
    assign issue_fire      = bus.issue_valid && bus.issue_ready;

    // Bit 0 is held at zero, so x0 never reads busy.
    assign bus.rs1_busy = busy_q[bus.rs1_addr];
    assign bus.rs2_busy = busy_q[bus.rs2_addr];

    wb_rr_arb #(
        .RR_EN (RR_EN)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .req0  (bus.wb0_valid),
        .req1  (bus.wb1_valid),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // Output stage always drains, so ready is simply the grant.
    assign bus.wb0_ready = gnt0;
    assign bus.wb1_ready = gnt1;

    always_comb begin
        wb_d     = wb_q;
        wb_d.wen = 1'b0;
        if (gnt0) begin
            wb_d.wen   = (bus.wb0_addr != '0);
            wb_d.waddr = bus.wb0_addr;
            wb_d.wdata = bus.wb0_data;
        end else if (gnt1) begin
            wb_d.wen   = (bus.wb1_addr != '0);
            wb_d.waddr = bus.wb1_addr;
            wb_d.wdata = bus.wb1_data;
        end
    end

    // Clear lands on the same edge rf commits, so the register reads busy until then.
    // Set and clear never hit the same bit: issue is blocked while it is busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_q.wen) begin
            busy_d[wb_q.waddr] = 1'b0;
        end
        if (issue_fire && bus.issue_rd != '0) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
            wb_q   <= '0;
        end else begin
            busy_q <= busy_d;
            wb_q   <= wb_d;
        end
    end

    assign bus.rd_wen   = wb_q.wen;
    assign bus.rd_waddr = wb_q.waddr;
    assign bus.rd_wdata = wb_q.wdata;

endmodule
